// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: default widths,
// timeout limit and the data-memory handshake FSM states.
package mem_stage_pkg;

    localparam int DATA_W_DEF   = 64;
    localparam int WR_W_DEF     = 32;
    localparam int MAX_WAIT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage and memory.
// master: req, we, addr, wdata out; rdata, ack in. slave: mirror.
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_stage_mem_wb_register.sv
// MEM/WB pipeline register: loads on en_i, otherwise inserts
// a bubble (valid/controls cleared, data fields held).
module mem_wb_register
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WR_W   = WR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [WR_W-1:0]   wr_i,
    input  logic              memToReg_i,
    input  logic              reg_write_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [WR_W-1:0]   wr_o,
    output logic              memToReg_o,
    output logic              reg_write_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o      <= 1'b0;
            read_data_o  <= '0;
            alu_result_o <= '0;
            wr_o         <= '0;
            memToReg_o   <= 1'b0;
            reg_write_o  <= 1'b0;
        end else if (en_i) begin
            valid_o      <= 1'b1;
            read_data_o  <= read_data_i;
            alu_result_o <= alu_result_i;
            wr_o         <= wr_i;
            memToReg_o   <= memToReg_i;
            reg_write_o  <= reg_write_i;
        end else begin
            valid_o      <= 1'b0;
            memToReg_o   <= 1'b0;
            reg_write_o  <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory handshake FSM, pipeline freeze,
// branch resolution and the MEM/WB register.
// Ports: EX/MEM fields in; stall_o/pc_src_o/branch_tgt_o out;
// dmem bus (master); wb_* MEM/WB outputs; sticky dmem_err.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WR_W     = WR_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pc_plus_imm,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [WR_W-1:0]   wr,
    input  logic [DATA_W-1:0] rd2,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              memToReg,
    input  logic              branch,
    input  logic              reg_write,
    input  logic              zero,
    output logic              stall_o,
    output logic              pc_src_o,
    output logic [DATA_W-1:0] branch_tgt_o,
    mem_stage_if.master       dmem,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_read_data,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [WR_W-1:0]   wb_wr,
    output logic              wb_memToReg,
    output logic              wb_reg_write,
    output logic              dmem_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_op;
    logic [DATA_W-1:0] wb_rdata_in;

    assign mem_op = mem_read | mem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    addr_d  = alu_result;
                    wdata_d = rd2;
                    we_d    = mem_write;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // An ack in the final wait cycle still wins.
                if (dmem.ack) begin
                    if (!we_q) begin
                        rdata_d = dmem.rdata;
                    end
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    cnt_d   = CNT_W'(MAX_WAIT);
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall_o = ((state_q == IDLE) & mem_op)
                   | (state_q == REQ);

    assign pc_src_o     = branch & zero;
    assign branch_tgt_o = pc_plus_imm;

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign dmem_err   = err_q;

    // The only unstalled edge of a memory op is in DONE.
    assign wb_rdata_in = ((state_q == DONE) && !we_q)
                       ? rdata_q : '0;

    mem_wb_register #(
        .DATA_W (DATA_W),
        .WR_W   (WR_W)
    ) u_mem_wb (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (~stall_o),
        .read_data_i  (wb_rdata_in),
        .alu_result_i (alu_result),
        .wr_i         (wr),
        .memToReg_i   (memToReg),
        .reg_write_i  (reg_write),
        .valid_o      (wb_valid),
        .read_data_o  (wb_read_data),
        .alu_result_o (wb_alu_result),
        .wr_o         (wb_wr),
        .memToReg_o   (wb_memToReg),
        .reg_write_o  (wb_reg_write)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-cycle
// ops, hand sequences for load, store, timeout and reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc_plus_imm, alu_result, rd2;
    logic [31:0] wr;
    logic        mem_read, mem_write, memToReg;
    logic        branch, reg_write, zero;
    logic        stall_o, pc_src_o;
    logic [63:0] branch_tgt_o;
    logic        wb_valid, wb_memToReg, wb_reg_write;
    logic [63:0] wb_read_data, wb_alu_result;
    logic [31:0] wb_wr;
    logic        dmem_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage_if #(.DATA_W(64)) dmem ();

    mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_plus_imm   (pc_plus_imm),
        .alu_result    (alu_result),
        .wr            (wr),
        .rd2           (rd2),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .memToReg      (memToReg),
        .branch        (branch),
        .reg_write     (reg_write),
        .zero          (zero),
        .stall_o       (stall_o),
        .pc_src_o      (pc_src_o),
        .branch_tgt_o  (branch_tgt_o),
        .dmem          (dmem),
        .wb_valid      (wb_valid),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .wb_wr         (wb_wr),
        .wb_memToReg   (wb_memToReg),
        .wb_reg_write  (wb_reg_write),
        .dmem_err      (dmem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic        zr;
        logic        rw;
        logic        m2r;
        logic [63:0] alu;
        logic [31:0] wr;
        logic [63:0] pci;
        logic        exp_src;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [63:0] alu);
        pc_plus_imm = '0;
        alu_result  = alu;
        rd2         = '0;
        wr          = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        memToReg    = 1'b0;
        branch      = 1'b0;
        reg_write   = 1'b0;
        zero        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stalls;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h10,
                    32'd5, 64'h0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h20,
                    32'd0, 64'h1000, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h30,
                    32'd0, 64'h2000, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h40,
                    32'd12, 64'h3000, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, '1,
                    32'd31, 64'hFFFF_0000, 1'b0};

        nop(64'h0);
        dmem.ack   = 1'b0;
        dmem.rdata = '0;

        // Reset state
        #1;
        chk("rst_req", 64'(dmem.req), 64'd0);
        chk("rst_valid", 64'(wb_valid), 64'd0);
        chk("rst_rdata", wb_read_data, 64'd0);
        chk("rst_err", 64'(dmem_err), 64'd0);
        chk("rst_addr", dmem.addr, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single-cycle ops from the table
        for (int i = 0; i < 5; i++) begin
            branch      = vecs[i].br;
            zero        = vecs[i].zr;
            reg_write   = vecs[i].rw;
            memToReg    = vecs[i].m2r;
            alu_result  = vecs[i].alu;
            wr          = vecs[i].wr;
            pc_plus_imm = vecs[i].pci;
            #1;
            chk("v_pc_src", 64'(pc_src_o),
                64'(vecs[i].exp_src));
            chk("v_tgt", branch_tgt_o, vecs[i].pci);
            chk("v_stall", 64'(stall_o), 64'd0);
            tick();
            chk("v_valid", 64'(wb_valid), 64'd1);
            chk("v_alu", wb_alu_result, vecs[i].alu);
            chk("v_wr", 64'(wb_wr), 64'(vecs[i].wr));
            chk("v_rw", 64'(wb_reg_write), 64'(vecs[i].rw));
            chk("v_m2r", 64'(wb_memToReg), 64'(vecs[i].m2r));
            chk("v_rdata", wb_read_data, 64'd0);
        end
        nop(64'h0);
        tick();

        // Load: ack on the 3rd REQ cycle
        mem_read   = 1'b1;
        alu_result = 64'h100;
        reg_write  = 1'b1;
        memToReg   = 1'b1;
        wr         = 32'd7;
        #1;
        stalls = 0;
        if (stall_o) stalls++;
        chk("ld_req0", 64'(dmem.req), 64'd0);
        tick();
        chk("ld_bubble", 64'(wb_valid), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            chk("ld_req", 64'(dmem.req), 64'd1);
            if (stall_o) stalls++;
            if (k == 3) begin
                dmem.ack   = 1'b1;
                dmem.rdata = 64'hDEAD;
            end
            tick();
            dmem.ack   = 1'b0;
            dmem.rdata = '0;
        end
        if (stall_o) stalls++;
        chk("ld_stalls", 64'(stalls), 64'd4);
        chk("ld_done_req", 64'(dmem.req), 64'd0);
        chk("ld_addr", dmem.addr, 64'h100);
        chk("ld_we", 64'(dmem.we), 64'd0);
        chk("ld_done_valid", 64'(wb_valid), 64'd0);
        tick();
        chk("ld_valid", 64'(wb_valid), 64'd1);
        chk("ld_rdata", wb_read_data, 64'hDEAD);
        chk("ld_wr", 64'(wb_wr), 64'd7);
        chk("ld_m2r", 64'(wb_memToReg), 64'd1);
        nop(64'h0);
        tick();
        chk("ld_noreissue", 64'(dmem.req), 64'd0);
        chk("ld_next_rdata", wb_read_data, 64'd0);

        // Store with both read and write set
        mem_write  = 1'b1;
        mem_read   = 1'b1;
        rd2        = 64'h55;
        alu_result = 64'h200;
        wr         = 32'd9;
        tick();
        chk("st_req", 64'(dmem.req), 64'd1);
        chk("st_we", 64'(dmem.we), 64'd1);
        chk("st_wdata", dmem.wdata, 64'h55);
        chk("st_addr", dmem.addr, 64'h200);
        dmem.ack   = 1'b1;
        dmem.rdata = 64'hBEEF;
        tick();
        dmem.ack   = 1'b0;
        dmem.rdata = '0;
        chk("st_stall", 64'(stall_o), 64'd0);
        tick();
        chk("st_valid", 64'(wb_valid), 64'd1);
        chk("st_rw", 64'(wb_reg_write), 64'd0);
        chk("st_rdata", wb_read_data, 64'd0);
        chk("st_wr", 64'(wb_wr), 64'd9);
        nop(64'h0);
        chk("pre_err", 64'(dmem_err), 64'd0);
        tick();

        // Timeout
        mem_read   = 1'b1;
        alu_result = 64'h300;
        reg_write  = 1'b1;
        tick();
        n = 0;
        while (dmem.req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("to_cycles", 64'(n), 64'd15);
        chk("to_req", 64'(dmem.req), 64'd0);
        chk("to_err", 64'(dmem_err), 64'd1);
        chk("to_stall", 64'(stall_o), 64'd0);
        tick();
        chk("to_valid", 64'(wb_valid), 64'd1);
        chk("to_rdata", wb_read_data, 64'd0);
        nop(64'h0);
        tick();
        tick();
        chk("to_sticky", 64'(dmem_err), 64'd1);

        // Access after timeout proceeds normally
        mem_read   = 1'b1;
        alu_result = 64'h308;
        tick();
        dmem.ack   = 1'b1;
        dmem.rdata = 64'h77;
        tick();
        dmem.ack   = 1'b0;
        dmem.rdata = '0;
        tick();
        chk("rc_rdata", wb_read_data, 64'h77);
        chk("rc_err", 64'(dmem_err), 64'd1);
        nop(64'h0);
        tick();

        // Spurious ack in IDLE
        dmem.ack   = 1'b1;
        dmem.rdata = 64'h99;
        #1;
        chk("sp_stall", 64'(stall_o), 64'd0);
        tick();
        dmem.ack   = 1'b0;
        dmem.rdata = '0;
        chk("sp_req", 64'(dmem.req), 64'd0);
        chk("sp_rdata", wb_read_data, 64'd0);
        chk("sp_valid", 64'(wb_valid), 64'd1);
        tick();
        chk("sp_req2", 64'(dmem.req), 64'd0);

        // Reset in the middle of REQ
        nop(64'hABC);
        wr = 32'd3;
        tick();
        mem_read   = 1'b1;
        alu_result = 64'h400;
        tick();
        chk("mr_req", 64'(dmem.req), 64'd1);
        chk("mr_alu_held", wb_alu_result, 64'hABC);
        #2;
        nop(64'h0);
        rst_n = 1'b0;
        #1;
        chk("mr_req0", 64'(dmem.req), 64'd0);
        chk("mr_stall", 64'(stall_o), 64'd0);
        chk("mr_alu", wb_alu_result, 64'd0);
        chk("mr_wr", 64'(wb_wr), 64'd0);
        chk("mr_valid", 64'(wb_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_idle_req", 64'(dmem.req), 64'd0);
        chk("mr_idle_stall", 64'(stall_o), 64'd0);
        chk("mr_idle_valid", 64'(wb_valid), 64'd1);
        chk("mr_err_clr", 64'(dmem_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
